// File: rtl/inv_pkg.sv
// rtl/inv_pkg.sv - shared constants and types for the inverting filter bank
// Purpose: default parameter values, glitch counter width/type and the
//          counter-width helper used by inv_filt_chan and inv_filt_bank.
// Ports:   none (package).
package inv_pkg;

  localparam int INV_WIDTH_DEF = 8;
  localparam int INV_SYNC_DEF  = 2;
  localparam int INV_FILT_DEF  = 4;
  localparam int GLITCH_CNT_W  = 16;

  typedef logic [GLITCH_CNT_W-1:0] glitch_cnt_t;

  // Filter counter width: enough to hold FILT_CYCLES-1, never less than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inv_filt_chan.sv
// rtl/inv_filt_chan.sv - one channel: synchroniser, debounce counter, filtered level
// Purpose: brings one asynchronous input into the clock domain and accepts a
//          new level only after it has persisted FILT_CYCLES enabled cycles.
// Ports:   i_clk       system clock
//          i_resetn    synchronous active-low reset
//          i_a         asynchronous raw input
//          i_enable    1 = filter runs, 0 = filter state frozen
//          o_filt      registered filtered level
//          o_filt_next value o_filt takes at the coming edge
//          o_glitch    a mismatch is being rejected at the coming edge
module inv_filt_chan
  import inv_pkg::*;
#(
  parameter int SYNC_STAGES = INV_SYNC_DEF,
  parameter int FILT_CYCLES = INV_FILT_DEF
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_a,
  input  logic i_enable,
  output logic o_filt,
  output logic o_filt_next,
  output logic o_glitch
);

  localparam int                CNT_W   = cnt_width(FILT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_filt;

  logic                   w_so;
  logic                   w_mismatch;
  logic                   w_filt_next;
  logic [CNT_W-1:0]       w_cnt_next;

  assign w_so       = r_sync[SYNC_STAGES-1];
  assign w_mismatch = (w_so != r_filt);

  always_comb begin
    w_filt_next = r_filt;
    w_cnt_next  = r_cnt;
    if (i_enable) begin
      if (!w_mismatch) begin
        w_cnt_next = '0;
      end else if (r_cnt == CNT_MAX) begin
        w_filt_next = w_so;
        w_cnt_next  = '0;
      end else begin
        w_cnt_next = r_cnt + CNT_ONE;
      end
    end
  end

  // The synchroniser runs regardless of i_enable so it never holds stale data.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_a};
      r_cnt  <= w_cnt_next;
      r_filt <= w_filt_next;
    end
  end

  assign o_filt      = r_filt;
  assign o_filt_next = w_filt_next;
  // Level went back to the accepted value before the count completed.
  assign o_glitch    = i_enable && !w_mismatch && (r_cnt != '0);

endmodule

// File: rtl/inv_filt_bank.sv
// rtl/inv_filt_bank.sv - bank of WIDTH synchronised, debounced, polarity-selectable inputs
// Purpose: conditions asynchronous pins into registered levels Y with a
//          one-cycle Changed strobe per channel.
// Ports:   Clock        system clock
//          nReset       synchronous active-low reset
//          A            asynchronous raw inputs
//          Invert       per-channel polarity (1 = Y is inverted filtered level)
//          Enable       1 = filters run, 0 = filters frozen
//          Y            registered conditioned outputs
//          Changed      one-cycle pulse when a channel's filtered level flips
//          ClearCount   (INV_FILT_GLITCH_CNT_EN only) clears GlitchCount
//          GlitchCount  (INV_FILT_GLITCH_CNT_EN only) saturating rejected-glitch count
// Macro:   INV_FILT_GLITCH_CNT_EN adds the glitch counter and its two ports.
module inv_filt_bank
  import inv_pkg::*;
#(
  parameter int WIDTH       = INV_WIDTH_DEF,
  parameter int SYNC_STAGES = INV_SYNC_DEF,
  parameter int FILT_CYCLES = INV_FILT_DEF
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic [WIDTH-1:0]        A,
  input  logic [WIDTH-1:0]        Invert,
  input  logic                    Enable,
`ifdef INV_FILT_GLITCH_CNT_EN
  input  logic                    ClearCount,
  output logic [GLITCH_CNT_W-1:0] GlitchCount,
`endif
  output logic [WIDTH-1:0]        Y,
  output logic [WIDTH-1:0]        Changed
);

  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] w_filt_next;
  logic [WIDTH-1:0] w_glitch;

  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_flip;
  logic [WIDTH-1:0] r_changed;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    inv_filt_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_chan (
      .i_clk       (Clock),
      .i_resetn    (nReset),
      .i_a         (A[g]),
      .i_enable    (Enable),
      .o_filt      (w_filt[g]),
      .o_filt_next (w_filt_next[g]),
      .o_glitch    (w_glitch[g])
    );
  end

  // Y samples the registered filt, so it shows a flip one edge after filt
  // moves; the flip is staged once in r_flip so Changed rises with Y.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_y       <= '0;
      r_flip    <= '0;
      r_changed <= '0;
    end else begin
      r_y       <= w_filt ^ Invert;
      r_flip    <= w_filt_next ^ w_filt;
      r_changed <= r_flip;
    end
  end

  assign Y       = r_y;
  assign Changed = r_changed;

`ifdef INV_FILT_GLITCH_CNT_EN
  glitch_cnt_t r_gcnt;

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_gcnt <= '0;
    end else if (ClearCount) begin
      r_gcnt <= '0;
    end else if ((|w_glitch) && (r_gcnt != '1)) begin
      r_gcnt <= r_gcnt + glitch_cnt_t'(1);
    end
  end

  assign GlitchCount = r_gcnt;
`else
  logic w_unused_glitch;
  assign w_unused_glitch = ^w_glitch;
`endif

endmodule

// File: tb/tb_inv_filt_bank.sv
// tb/tb_inv_filt_bank.sv - self-checking bench for inv_filt_bank (default parameters)
module tb_inv_filt_bank;

  logic       Clock;
  logic       nReset;
  logic       Enable;
  logic [7:0] A;
  logic [7:0] Invert;
  logic [7:0] Y;
  logic [7:0] Changed;
`ifdef INV_FILT_GLITCH_CNT_EN
  logic        ClearCount;
  logic [15:0] GlitchCount;
`endif

  int total;
  int bad;

  typedef struct {
    logic [7:0] y;
    logic [7:0] ch;
    string      nm;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic       nr;
    logic [7:0] a;
    logic [7:0] inv;
    logic [7:0] ey;
    logic [7:0] ech;
  } vec_t;

  vec_t tbl[11];

  inv_filt_bank dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .A           (A),
    .Invert      (Invert),
    .Enable      (Enable),
`ifdef INV_FILT_GLITCH_CNT_EN
    .ClearCount  (ClearCount),
    .GlitchCount (GlitchCount),
`endif
    .Y           (Y),
    .Changed     (Changed)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, queue expectation, sample 1ns after posedge.
  task automatic step(input logic nr, input logic en, input logic [7:0] a,
                      input logic [7:0] inv, input bit chk,
                      input logic [7:0] ey, input logic [7:0] ech, input string nm);
    exp_t e;
    @(negedge Clock);
    nReset = nr;
    Enable = en;
    A      = a;
    Invert = inv;
    if (chk) begin
      e.y  = ey;
      e.ch = ech;
      e.nm = nm;
      sb.push_back(e);
    end
    @(posedge Clock);
    #1;
    if (chk) begin
      e = sb.pop_front();
      check({e.nm, ".y"}, {8'h00, Y}, {8'h00, e.y});
      check({e.nm, ".ch"}, {8'h00, Changed}, {8'h00, e.ch});
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    nReset = 1'b0;
    Enable = 1'b1;
    A      = 8'h00;
    Invert = 8'h00;
`ifdef INV_FILT_GLITCH_CNT_EN
    ClearCount = 1'b0;
`endif

    // Reset with A=FF, Invert=0F, then release: filt flips at edge 6,
    // Y/Changed show it at edge 7.
    tbl[0]  = '{1'b0, 8'hFF, 8'h0F, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 8'hFF, 8'h0F, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 8'hFF, 8'h0F, 8'h00, 8'h00};
    tbl[3]  = '{1'b1, 8'hFF, 8'h0F, 8'h0F, 8'h00};
    tbl[4]  = '{1'b1, 8'hFF, 8'h0F, 8'h0F, 8'h00};
    tbl[5]  = '{1'b1, 8'hFF, 8'h0F, 8'h0F, 8'h00};
    tbl[6]  = '{1'b1, 8'hFF, 8'h0F, 8'h0F, 8'h00};
    tbl[7]  = '{1'b1, 8'hFF, 8'h0F, 8'h0F, 8'h00};
    tbl[8]  = '{1'b1, 8'hFF, 8'h0F, 8'h0F, 8'h00};
    tbl[9]  = '{1'b1, 8'hFF, 8'h0F, 8'hF0, 8'hFF};
    tbl[10] = '{1'b1, 8'hFF, 8'h0F, 8'hF0, 8'h00};

    for (int i = 0; i < 11; i++)
      step(tbl[i].nr, 1'b1, tbl[i].a, tbl[i].inv, 1'b1, tbl[i].ey, tbl[i].ech, "reset_tbl");

    // Latency, true polarity.
    for (int i = 1; i <= 10; i++)
      step(1'b1, 1'b1, 8'h00, 8'h00, i == 10, 8'h00, 8'h00, "settle0");
    for (int i = 1; i <= 8; i++)
      step(1'b1, 1'b1, 8'h01, 8'h00, 1'b1, (i >= 7) ? 8'h01 : 8'h00,
           (i == 7) ? 8'h01 : 8'h00, "lat_true");

    // Latency, inverted polarity on channel 0.
    for (int i = 1; i <= 10; i++)
      step(1'b1, 1'b1, 8'h00, 8'h01, i == 10, 8'h01, 8'h00, "settle_inv");
    for (int i = 1; i <= 8; i++)
      step(1'b1, 1'b1, 8'h01, 8'h01, 1'b1, (i >= 7) ? 8'h00 : 8'h01,
           (i == 7) ? 8'h01 : 8'h00, "lat_inv");

    // Glitch on channel 3: high for 3 cycles only.
    for (int i = 1; i <= 3; i++)
      step(1'b1, 1'b1, 8'h01, 8'h00, i == 3, 8'h01, 8'h00, "settle_gl");
`ifdef INV_FILT_GLITCH_CNT_EN
    check("gcnt_before", GlitchCount, 16'h0000);
`endif
    for (int i = 1; i <= 10; i++)
      step(1'b1, 1'b1, (i <= 3) ? 8'h09 : 8'h01, 8'h00, 1'b1, 8'h01, 8'h00, "glitch");
`ifdef INV_FILT_GLITCH_CNT_EN
    check("gcnt_after", GlitchCount, 16'h0001);
    ClearCount = 1'b1;
    step(1'b1, 1'b1, 8'h01, 8'h00, 1'b0, 8'h00, 8'h00, "clear");
    ClearCount = 1'b0;
    check("gcnt_clear", GlitchCount, 16'h0000);
`endif

    // Enable freeze on channel 1 after 2 counted cycles.
    for (int i = 1; i <= 18; i++)
      step(1'b1, (i >= 5 && i <= 14) ? 1'b0 : 1'b1, 8'h03, 8'h00, 1'b1,
           (i >= 17) ? 8'h03 : 8'h01, (i == 17) ? 8'h02 : 8'h00, "freeze");

    // Invert toggle only: no Changed pulse.
    for (int i = 1; i <= 10; i++)
      step(1'b1, 1'b1, 8'hAA, 8'h00, i == 10, 8'hAA, 8'h00, "settle_aa");
    for (int i = 1; i <= 2; i++)
      step(1'b1, 1'b1, 8'hAA, 8'hFF, 1'b1, 8'h55, 8'h00, "inv_toggle");

    // Reset after 3 counted cycles on channel 2; count must not survive.
    for (int i = 1; i <= 5; i++)
      step(1'b1, 1'b1, 8'hAE, 8'h00, 1'b1, 8'hAA, 8'h00, "mid_count");
    for (int i = 1; i <= 2; i++)
      step(1'b0, 1'b1, 8'hAE, 8'h00, 1'b1, 8'h00, 8'h00, "mid_reset");
    for (int i = 1; i <= 8; i++)
      step(1'b1, 1'b1, 8'hAE, 8'h00, 1'b1, (i >= 7) ? 8'hAE : 8'h00,
           (i == 7) ? 8'hAE : 8'h00, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
